board_edit_ctrl: RTL and testbench

Sequencing controller for the board-write datapath. It turns single-cycle button pulses into cursor moves, value selection and write commands (`wr_en`, `wr_i`, `wr_j`, `wr_value`) that drive the board-update stage, and it refuses writes to initial (status 0) squares. A clear command walks all 81 cells and blanks every editable one, one cell per cycle.

---
 rtl/board_edit_ctrl_if.sv | 33 +++
 rtl/board_edit_ctrl.sv | 152 +++++++++++++++
 tb/tb_board_edit_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/board_edit_ctrl_if.sv
// Board-edit bus: button pulses and status grid in, cursor/edit state and write commands out.
interface board_edit_ctrl_if #(
   parameter int unsigned N = 9
);
   logic                       btn_up;
   logic                       btn_down;
   logic                       btn_left;
   logic                       btn_right;
   logic                       btn_inc;
   logic                       btn_commit;
   logic                       btn_clear;
   logic [N-1:0][N-1:0][3:0]   status_grid;
   logic [3:0]                 cur_i;
   logic [3:0]                 cur_j;
   logic [3:0]                 edit_value;
   logic                       locked;
   logic                       wr_en;
   logic [3:0]                 wr_i;
   logic [3:0]                 wr_j;
   logic [3:0]                 wr_value;
   logic                       busy;
   logic                       err;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, btn_inc, btn_commit, btn_clear, status_grid,
      input  cur_i, cur_j, edit_value, locked, wr_en, wr_i, wr_j, wr_value, busy, err
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, btn_inc, btn_commit, btn_clear, status_grid,
      output cur_i, cur_j, edit_value, locked, wr_en, wr_i, wr_j, wr_value, busy, err
   );
endinterface

// File: rtl/board_edit_ctrl.sv
// Board-edit sequencer: cursor/value editing, guarded single-cell commit and full-board clear walk.
module board_edit_ctrl #(
   parameter int unsigned N = 9
) (
   input logic             clock,
   input logic             reset_n,
   board_edit_ctrl_if.slave bus
);
   localparam int unsigned IW   = 4;
   localparam int unsigned VW   = 4;
   localparam int unsigned VMAX = 9;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, COMMIT, CLEAR} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   cur_i_q, cur_i_d, cur_j_q, cur_j_d;
   logic [VW-1:0]   val_q, val_d;
   logic [IW-1:0]   scan_i_q, scan_i_d, scan_j_q, scan_j_d;
   logic [IW-1:0]   wr_i_q, wr_i_d, wr_j_q, wr_j_d;
   logic [VW-1:0]   wr_value_q, wr_value_d;
   logic            wr_en_q, wr_en_d;
   logic            busy_q, busy_d;
   logic            err_q, err_d;
   logic            locked_c;
   logic [IW-1:0]   next_i, next_j;

   // Lock flag follows the live cursor with no register delay.
   assign locked_c = (bus.status_grid[cur_i_q][cur_j_q] == 4'd0);

   // Row-major successor of the current scan position.
   always_comb begin
      next_j = (scan_j_q == LAST) ? '0 : IW'(scan_j_q + 1'b1);
      next_i = (scan_j_q == LAST) ? IW'(scan_i_q + 1'b1) : scan_i_q;
   end

   // State register and all registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cur_i_q    <= '0;
         cur_j_q    <= '0;
         val_q      <= '0;
         scan_i_q   <= '0;
         scan_j_q   <= '0;
         wr_i_q     <= '0;
         wr_j_q     <= '0;
         wr_value_q <= '0;
         wr_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_i_q    <= cur_i_d;
         cur_j_q    <= cur_j_d;
         val_q      <= val_d;
         scan_i_q   <= scan_i_d;
         scan_j_q   <= scan_j_d;
         wr_i_q     <= wr_i_d;
         wr_j_q     <= wr_j_d;
         wr_value_q <= wr_value_d;
         wr_en_q    <= wr_en_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   // Next-state and next-output logic; IDLE serves one button per cycle by fixed priority.
   always_comb begin
      state_d    = state_q;
      cur_i_d    = cur_i_q;
      cur_j_d    = cur_j_q;
      val_d      = val_q;
      scan_i_d   = scan_i_q;
      scan_j_d   = scan_j_q;
      wr_i_d     = wr_i_q;
      wr_j_d     = wr_j_q;
      wr_value_d = wr_value_q;
      wr_en_d    = 1'b0;
      busy_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.btn_clear) begin
               // Cell (0,0) is presented in the first CLEAR cycle.
               state_d    = CLEAR;
               busy_d     = 1'b1;
               scan_i_d   = '0;
               scan_j_d   = '0;
               wr_i_d     = '0;
               wr_j_d     = '0;
               wr_value_d = '0;
               wr_en_d    = (bus.status_grid[0][0] != 4'd0);
            end else if (bus.btn_commit) begin
               if (locked_c) begin
                  err_d = 1'b1;
               end else begin
                  state_d    = COMMIT;
                  wr_en_d    = 1'b1;
                  wr_i_d     = cur_i_q;
                  wr_j_d     = cur_j_q;
                  wr_value_d = val_q;
               end
            end else if (bus.btn_up) begin
               cur_i_d = (cur_i_q == '0) ? LAST : IW'(cur_i_q - 1'b1);
            end else if (bus.btn_down) begin
               cur_i_d = (cur_i_q == LAST) ? '0 : IW'(cur_i_q + 1'b1);
            end else if (bus.btn_left) begin
               cur_j_d = (cur_j_q == '0) ? LAST : IW'(cur_j_q - 1'b1);
            end else if (bus.btn_right) begin
               cur_j_d = (cur_j_q == LAST) ? '0 : IW'(cur_j_q + 1'b1);
            end else if (bus.btn_inc) begin
               val_d = (val_q == VW'(VMAX)) ? '0 : VW'(val_q + 1'b1);
            end
         end

         COMMIT: begin
            state_d = IDLE;
         end

         CLEAR: begin
            if (scan_i_q == LAST && scan_j_q == LAST) begin
               state_d = IDLE;
            end else begin
               busy_d     = 1'b1;
               scan_i_d   = next_i;
               scan_j_d   = next_j;
               wr_i_d     = next_i;
               wr_j_d     = next_j;
               wr_value_d = '0;
               wr_en_d    = (bus.status_grid[next_i][next_j] != 4'd0);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.cur_i      = cur_i_q;
   assign bus.cur_j      = cur_j_q;
   assign bus.edit_value = val_q;
   assign bus.locked     = locked_c;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_i       = wr_i_q;
   assign bus.wr_j       = wr_j_q;
   assign bus.wr_value   = wr_value_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_board_edit_ctrl.sv
// Self-checking bench for board_edit_ctrl: cycle model plus directed literal checks.
module tb_board_edit_ctrl;
   logic clock;
   logic reset_n;

   board_edit_ctrl_if #(.N(9)) bif ();

   board_edit_ctrl #(.N(9)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Model state: cursor, value, mode (0 idle, 1 commit, 2 clear), scan index 0..80.
   int m_ci, m_cj, m_ev, m_mode, m_scan;
   int m_wi, m_wj, m_wv;
   bit m_wr, m_busy, m_err;

   function automatic bit cell_on(input int m);
      return bif.status_grid[m / 9][m % 9] != 4'd0;
   endfunction

   // Reference model: advances on each edge from the spec's rules.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_ci = 0; m_cj = 0; m_ev = 0; m_mode = 0; m_scan = 0;
         m_wi = 0; m_wj = 0; m_wv = 0; m_wr = 0; m_busy = 0; m_err = 0;
      end else begin
         m_wr  = 0;
         m_err = 0;
         if (m_mode == 2) begin
            m_scan++;
            if (m_scan == 81) begin
               m_mode = 0;
               m_busy = 0;
            end else begin
               m_wi = m_scan / 9; m_wj = m_scan % 9; m_wv = 0; m_wr = cell_on(m_scan);
            end
         end else if (m_mode == 1) begin
            m_mode = 0;
         end else if (bif.btn_clear) begin
            m_mode = 2; m_scan = 0; m_busy = 1;
            m_wi = 0; m_wj = 0; m_wv = 0; m_wr = cell_on(0);
         end else if (bif.btn_commit) begin
            if (bif.status_grid[m_ci][m_cj] != 4'd0) begin
               m_mode = 1; m_wr = 1; m_wi = m_ci; m_wj = m_cj; m_wv = m_ev;
            end else begin
               m_err = 1;
            end
         end else if (bif.btn_up)    m_ci = (m_ci + 8) % 9;
         else if (bif.btn_down)      m_ci = (m_ci + 1) % 9;
         else if (bif.btn_left)      m_cj = (m_cj + 8) % 9;
         else if (bif.btn_right)     m_cj = (m_cj + 1) % 9;
         else if (bif.btn_inc)       m_ev = (m_ev + 1) % 10;
      end
   end

   int busy_cnt, clr_wr, nz_wr, any_wr;

   // Compare DUT against the model mid-cycle, and tally clear activity.
   always @(negedge clock) begin
      if (cmp_en) begin
         chk("wr_en", int'(bif.wr_en), int'(m_wr));
         if (m_wr) begin
            chk("wr_i", int'(bif.wr_i), m_wi);
            chk("wr_j", int'(bif.wr_j), m_wj);
            chk("wr_value", int'(bif.wr_value), m_wv);
         end
         chk("cur_i", int'(bif.cur_i), m_ci);
         chk("cur_j", int'(bif.cur_j), m_cj);
         chk("edit_value", int'(bif.edit_value), m_ev);
         chk("busy", int'(bif.busy), int'(m_busy));
         chk("err", int'(bif.err), int'(m_err));
         chk("locked", int'(bif.locked), int'(bif.status_grid[m_ci][m_cj] == 4'd0));
      end
      if (bif.busy) busy_cnt++;
      if (bif.wr_en) any_wr++;
      if (bif.wr_en && bif.busy) begin
         clr_wr++;
         if (bif.wr_value != 4'd0) nz_wr++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   // Mask bits: {clear, commit, up, down, left, right, inc}.
   task automatic press(input logic [6:0] m);
      bif.btn_clear  = m[6];
      bif.btn_commit = m[5];
      bif.btn_up     = m[4];
      bif.btn_down   = m[3];
      bif.btn_left   = m[2];
      bif.btn_right  = m[1];
      bif.btn_inc    = m[0];
      tick(1);
      bif.btn_clear = 0; bif.btn_commit = 0; bif.btn_up = 0; bif.btn_down = 0;
      bif.btn_left = 0; bif.btn_right = 0; bif.btn_inc = 0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 100 && bif.busy; n++) tick(1);
      chk("busy_done", int'(bif.busy), 0);
   endtask

   localparam logic [6:0] B_CLEAR = 7'b1000000;
   localparam logic [6:0] B_COMMIT = 7'b0100000;
   localparam logic [6:0] B_UP = 7'b0010000;
   localparam logic [6:0] B_DOWN = 7'b0001000;
   localparam logic [6:0] B_LEFT = 7'b0000100;
   localparam logic [6:0] B_RIGHT = 7'b0000010;
   localparam logic [6:0] B_INC = 7'b0000001;

   initial begin
      int snap;
      reset_n = 1;
      bif.btn_clear = 0; bif.btn_commit = 0; bif.btn_up = 0; bif.btn_down = 0;
      bif.btn_left = 0; bif.btn_right = 0; bif.btn_inc = 0;
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 9; j++)
            bif.status_grid[i][j] = 4'd1;
      #1 reset_n = 0;
      cmp_en = 1;
      #20;
      @(posedge clock);
      #2 reset_n = 1;

      // Reset values.
      chk("rst_cur_i", int'(bif.cur_i), 0);
      chk("rst_cur_j", int'(bif.cur_j), 0);
      chk("rst_edit_value", int'(bif.edit_value), 0);
      chk("rst_wr_en", int'(bif.wr_en), 0);
      chk("rst_wr_i", int'(bif.wr_i), 0);
      chk("rst_busy", int'(bif.busy), 0);
      chk("rst_err", int'(bif.err), 0);

      // Wrap behaviour.
      press(B_UP);    chk("wrap_up", int'(bif.cur_i), 8);
      press(B_LEFT);  chk("wrap_left", int'(bif.cur_j), 8);
      press(B_RIGHT); chk("wrap_right", int'(bif.cur_j), 0);
      for (int k = 0; k < 10; k++) press(B_INC);
      chk("inc_wrap", int'(bif.edit_value), 0);

      // Move to (3,5), value 7.
      press(B_DOWN);
      for (int k = 0; k < 3; k++) press(B_DOWN);
      for (int k = 0; k < 5; k++) press(B_RIGHT);
      for (int k = 0; k < 7; k++) press(B_INC);
      chk("pos_i", int'(bif.cur_i), 3);
      chk("pos_j", int'(bif.cur_j), 5);
      chk("val7", int'(bif.edit_value), 7);

      // Accepted commit, with a back-to-back second commit that must be dropped.
      bif.status_grid[3][5] = 4'd2;
      tick(1);
      snap = any_wr;
      press(B_COMMIT);
      chk("commit_wr_en", int'(bif.wr_en), 1);
      chk("commit_wr_i", int'(bif.wr_i), 3);
      chk("commit_wr_j", int'(bif.wr_j), 5);
      chk("commit_wr_value", int'(bif.wr_value), 7);
      press(B_COMMIT);
      chk("commit_drop", int'(bif.wr_en), 0);
      tick(3);
      chk("commit_count", any_wr - snap, 1);

      // Rejected commit on a locked cell.
      bif.status_grid[3][5] = 4'd0;
      tick(1);
      chk("locked_now", int'(bif.locked), 1);
      snap = any_wr;
      press(B_COMMIT);
      chk("reject_err", int'(bif.err), 1);
      chk("reject_wr_en", int'(bif.wr_en), 0);
      tick(1);
      chk("reject_err_clr", int'(bif.err), 0);
      chk("reject_count", any_wr - snap, 0);

      // Clear with 30 editable cells; buttons during busy are ignored.
      for (int m = 0; m < 81; m++)
         bif.status_grid[m / 9][m % 9] = (m < 45 && (m % 3) != 2) ? 4'((m % 15) + 1) : 4'd0;
      tick(1);
      busy_cnt = 0; clr_wr = 0; nz_wr = 0;
      press(B_CLEAR);
      tick(10);
      press(B_COMMIT);
      press(B_RIGHT);
      press(B_INC);
      wait_idle();
      chk("clear_busy_cycles", busy_cnt, 81);
      chk("clear_writes", clr_wr, 30);
      chk("clear_nz_values", nz_wr, 0);
      chk("clear_cur_j", int'(bif.cur_j), 5);
      chk("clear_val", int'(bif.edit_value), 7);

      // Simultaneous clear + commit + right: clear wins.
      busy_cnt = 0; clr_wr = 0; nz_wr = 0;
      press(B_CLEAR | B_COMMIT | B_RIGHT);
      chk("simul_busy", int'(bif.busy), 1);
      wait_idle();
      chk("simul_busy_cycles", busy_cnt, 81);
      chk("simul_nz_values", nz_wr, 0);
      chk("simul_cur_j", int'(bif.cur_j), 5);

      // Reset at scan cell 40 aborts the walk.
      press(B_CLEAR);
      tick(40);
      chk("cell40_i", int'(bif.wr_i), 4);
      chk("cell40_j", int'(bif.wr_j), 4);
      chk("cell40_wr_en", int'(bif.wr_en), 1);
      reset_n = 0;
      #1;
      chk("abort_wr_en", int'(bif.wr_en), 0);
      chk("abort_busy", int'(bif.busy), 0);
      chk("abort_cur_i", int'(bif.cur_i), 0);
      chk("abort_val", int'(bif.edit_value), 0);
      tick(2);
      reset_n = 1;
      snap = any_wr;
      tick(20);
      chk("post_reset_writes", any_wr - snap, 0);
      chk("post_reset_busy", int'(bif.busy), 0);

      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
